// File: rtl/rv_pkg.sv
// rv_pkg: opcode classes, forwarding encodings, sequencer states and the
// in-flight shadow entry shared by the hazard control unit.
package rv_pkg;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {RUN, BUBBLE, FREEZE} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } shadow_t;

    // x0 is never a producer, so an entry only counts if it really writes.
    function automatic logic hits(input shadow_t e, input logic [4:0] rs);
        return e.valid & e.we & (e.rd != 5'd0) & (e.rd == rs);
    endfunction
endpackage

// File: rtl/hazard_fwd_compare.sv
// hazard_fwd_compare: matches one decode source register against the EX and
// MEM shadows, yielding its forwarding select and a load-use flag.
module hazard_fwd_compare
    import rv_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic       i_use,
    input  shadow_t    i_ex,
    input  shadow_t    i_mem,
    output logic [1:0] o_fwd_sel,
    output logic       o_load_use
);
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_unused_mem_ld;

    assign w_unused_mem_ld = i_mem.is_load;

    // A load in EX has no result yet, so it stalls instead of forwarding.
    always_comb begin
        w_ex_hit   = i_use & hits(i_ex, i_rs);
        w_mem_hit  = i_use & hits(i_mem, i_rs);
        o_load_use = w_ex_hit & i_ex.is_load;
        o_fwd_sel  = (w_ex_hit & !i_ex.is_load) ? FWD_EX : w_mem_hit ? FWD_MEM : FWD_RF;
    end
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: issue gating, load-use bubbles, forwarding selects and
// memory-stall freeze for the decode/EX boundary of the 5-stage pipeline.
module hazard_control_unit
    import rv_pkg::*;
#(
    parameter  int XLEN_REGS = 32,
    parameter  int CNT_W     = 32,
    localparam int RW        = $clog2(XLEN_REGS)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_id_valid,
    input  logic [6:0]       i_id_opcode,
    input  logic [RW-1:0]    i_id_rd,
    input  logic [RW-1:0]    i_id_rs1,
    input  logic [RW-1:0]    i_id_rs2,
    output logic             o_id_ready,
    input  logic             i_flush,
    input  logic             i_mem_busy,
    output logic             o_ex_valid,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel,
    output logic             o_wb_we,
    output logic [RW-1:0]    o_wb_rd,
    output logic [CNT_W-1:0] o_stall_count
);
    shadow_t          r_ex, r_mem, r_wb, w_id;
    state_t           r_state, w_state_nxt;
    logic             r_flush_pend;
    logic [CNT_W-1:0] r_stall_count;
    logic             w_is_r, w_is_i, w_is_ld, w_is_st, w_use1, w_use2;
    logic             w_lu_a, w_lu_b, w_hazard, w_flush, w_ready;
    logic             w_unused_wb_ld;

    hazard_fwd_compare u_cmp_a (
        .i_rs(5'(i_id_rs1)), .i_use(w_use1), .i_ex(r_ex), .i_mem(r_mem),
        .o_fwd_sel(o_fwd_a_sel), .o_load_use(w_lu_a)
    );

    hazard_fwd_compare u_cmp_b (
        .i_rs(5'(i_id_rs2)), .i_use(w_use2), .i_ex(r_ex), .i_mem(r_mem),
        .o_fwd_sel(o_fwd_b_sel), .o_load_use(w_lu_b)
    );

    always_comb begin
        w_is_r          = i_id_opcode == OP_R;
        w_is_i          = i_id_opcode == OP_I;
        w_is_ld         = i_id_opcode == OP_LOAD;
        w_is_st         = i_id_opcode == OP_STORE;
        w_use1          = w_is_r | w_is_i | w_is_ld | w_is_st;
        w_use2          = w_is_r | w_is_st;
        w_id.valid      = 1'b1;
        w_id.rd         = 5'(i_id_rd);
        w_id.we         = (w_is_r | w_is_i | w_is_ld) & (i_id_rd != '0);
        w_id.is_load    = w_is_ld;
        w_flush         = i_flush | r_flush_pend;
        w_hazard        = i_id_valid & (w_lu_a | w_lu_b);
        w_ready         = !reset & i_id_valid & !i_mem_busy & !w_flush & !w_hazard;
        w_state_nxt     = i_mem_busy ? FREEZE
                        : (r_state == RUN && w_hazard && !w_flush) ? BUBBLE : RUN;
    end

    // A flush seen while frozen is remembered and applied once memory releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex          <= '0;
            r_mem         <= '0;
            r_wb          <= '0;
            r_state       <= RUN;
            r_flush_pend  <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_pend <= i_mem_busy & w_flush;
            if (i_id_valid & !w_ready & ~&r_stall_count)
                r_stall_count <= r_stall_count + CNT_W'(1);
            if (!i_mem_busy) begin
                r_ex  <= w_ready ? w_id : '0;
                r_mem <= w_flush ? '0 : r_ex;
                r_wb  <= r_mem;
            end
        end
    end

    assign w_unused_wb_ld = r_wb.is_load;
    assign o_id_ready     = w_ready;
    assign o_ex_valid     = r_ex.valid;
    assign o_wb_we        = r_wb.valid & r_wb.we & !i_mem_busy;
    assign o_wb_rd        = RW'(r_wb.rd);
    assign o_stall_count  = r_stall_count;
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed vectors with hand-computed per-cycle
// expectations, queued by the driver and checked by an independent monitor.
module tb_hazard_control_unit;
    localparam logic [6:0] ADD = 7'b0110011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] NOP = 7'b0000000;

    typedef struct packed {
        logic       rdy;
        logic       exv;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       we;
        logic [4:0] wrd;
        logic [3:0] sc;
    } vec_t;

    typedef struct {
        string nm;
        vec_t  v;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0, flush = 1'b0, mem_busy = 1'b0;
    logic [6:0] id_opcode = '0;
    logic [4:0] id_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic       id_ready, ex_valid, wb_we;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [4:0] wb_rd;
    logic [3:0] stall_count;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    hazard_control_unit #(.XLEN_REGS(32), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .i_id_valid(id_valid), .i_id_opcode(id_opcode),
        .i_id_rd(id_rd), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .o_id_ready(id_ready),
        .i_flush(flush), .i_mem_busy(mem_busy), .o_ex_valid(ex_valid),
        .o_fwd_a_sel(fwd_a_sel), .o_fwd_b_sel(fwd_b_sel), .o_wb_we(wb_we),
        .o_wb_rd(wb_rd), .o_stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic step(input string nm, input logic v, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic fl, input logic mb, input logic rst,
                        input logic rdy, input logic exv, input logic [1:0] fa,
                        input logic [1:0] fb, input logic we, input logic [4:0] wrd,
                        input logic [3:0] sc);
        exp_t e;
        @(posedge clk);
        #1;
        id_valid  = v;
        id_opcode = op;
        id_rd     = rd;
        id_rs1    = rs1;
        id_rs2    = rs2;
        flush     = fl;
        mem_busy  = mb;
        reset     = rst;
        e.nm = nm;
        e.v  = '{rdy: rdy, exv: exv, fa: fa, fb: fb, we: we, wrd: wrd, sc: sc};
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            vec_t a;
            e = q.pop_front();
            a = '{rdy: id_ready, exv: ex_valid, fa: fwd_a_sel, fb: fwd_b_sel,
                  we: wb_we, wrd: wb_rd, sc: stall_count};
            n_chk++;
            if (a !== e.v) begin
                n_fail++;
                $display("FAIL %s: got rdy=%b exv=%b fa=%b fb=%b we=%b rd=%0d sc=%0d, expected rdy=%b exv=%b fa=%b fb=%b we=%b rd=%0d sc=%0d",
                         e.nm, a.rdy, a.exv, a.fa, a.fb, a.we, a.wrd, a.sc,
                         e.v.rdy, e.v.exv, e.v.fa, e.v.fb, e.v.we, e.v.wrd, e.v.sc);
            end
        end
    end

    initial begin
        //    name          v  op   rd  rs1 rs2 fl mb rst  rdy exv fa     fb     we wrd sc
        step("reset",       1, ADD,  3,  1,  2, 0, 0, 1,   0,  0, 2'b00, 2'b00, 0,  0, 0);
        step("add_x3",      1, ADD,  3,  1,  2, 0, 0, 0,   1,  0, 2'b00, 2'b00, 0,  0, 0);
        step("fwd_ex",      1, ADD,  4,  3,  1, 0, 0, 0,   1,  1, 2'b01, 2'b00, 0,  0, 0);
        step("lw_x5",       1, LW,   5,  4,  0, 0, 0, 0,   1,  1, 2'b01, 2'b00, 0,  0, 0);
        step("load_use",    1, ADD,  6,  5,  5, 0, 0, 0,   0,  1, 2'b00, 2'b00, 1,  3, 0);
        step("after_bub",   1, ADD,  6,  5,  5, 0, 0, 0,   1,  0, 2'b10, 2'b10, 1,  4, 1);
        step("add_x0",      1, ADD,  0,  1,  2, 0, 0, 0,   1,  1, 2'b00, 2'b00, 1,  5, 1);
        step("sub_x0x0",    1, ADD,  7,  0,  0, 0, 0, 0,   1,  1, 2'b00, 2'b00, 0,  0, 1);
        step("lw_x8",       1, LW,   8,  1,  0, 0, 0, 0,   1,  1, 2'b00, 2'b00, 1,  6, 1);
        step("x0_wb",       0, NOP,  0,  0,  0, 0, 0, 0,   0,  1, 2'b00, 2'b00, 0,  0, 1);
        for (int i = 0; i < 4; i++)
            step("freeze",  1, ADD,  9,  8,  7, 0, 1, 0,   0,  0, 2'b10, 2'b00, 0,  7, 4'(1 + i));
        step("release",     1, ADD,  9,  8,  7, 0, 0, 0,   1,  0, 2'b10, 2'b00, 1,  7, 5);
        step("lw_x8_wb",    1, ADD, 12,  1,  2, 0, 0, 0,   1,  1, 2'b00, 2'b00, 1,  8, 5);
        step("lw_x10",      1, LW,  10,  1,  0, 0, 0, 0,   1,  1, 2'b00, 2'b00, 0,  0, 5);
        step("flush",       1, ADD, 11, 10, 10, 1, 0, 0,   0,  1, 2'b00, 2'b00, 1,  9, 5);
        step("post_flush",  1, ADD, 13, 10, 12, 0, 0, 0,   1,  0, 2'b00, 2'b00, 1, 12, 6);
        step("killed_lw",   0, NOP,  0,  0,  0, 0, 0, 0,   0,  1, 2'b00, 2'b00, 0,  0, 6);
        step("flush_frz",   1, ADD, 14, 13,  0, 1, 1, 0,   0,  0, 2'b10, 2'b00, 0,  0, 6);
        step("flush_pend",  1, ADD, 14, 13,  0, 0, 0, 0,   0,  0, 2'b10, 2'b00, 0,  0, 7);
        step("x14_issue",   1, ADD, 14, 13,  0, 0, 0, 0,   1,  0, 2'b00, 2'b00, 1, 13, 8);
        step("x15_issue",   1, ADD, 15,  1,  2, 0, 0, 0,   1,  1, 2'b00, 2'b00, 0,  0, 8);
        step("x16_issue",   1, ADD, 16,  1,  2, 0, 0, 0,   1,  1, 2'b00, 2'b00, 0,  0, 8);
        step("mid_reset",   1, ADD, 17, 16, 15, 0, 0, 1,   0,  0, 2'b00, 2'b00, 0,  0, 0);
        for (int i = 0; i < 3; i++)
            step("no_wb",   0, NOP,  0,  0,  0, 0, 0, 0,   0,  0, 2'b00, 2'b00, 0,  0, 0);
        for (int i = 0; i < 20; i++)
            step("saturate", 1, NOP, 0,  0,  0, 0, 1, 0,   0,  0, 2'b00, 2'b00, 0,  0, 4'(i > 15 ? 15 : i));
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
